// File: rtl/mac_array_skewed.sv
// Weight-stationary row x col systolic MAC array with internal input skew and output deskew.
// Optional L1-distance mode is built when MAC_ARRAY_SKEWED_L1_EN is defined.

module mas_delay #(
    parameter int W = 1,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    logic [W-1:0] stage_r [D];

    // Fixed-length shift chain
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < D; i++) stage_r[i] <= '0;
        end else begin
            stage_r[0] <= din;
            for (int i = 1; i < D; i++) stage_r[i] <= stage_r[i-1];
        end
    end

    assign dout = stage_r[D-1];
endmodule

module mac_array_skewed #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int row     = 8,
    parameter int col     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [row*bw-1:0]      in_w,
    input  logic [psum_bw*col-1:0] in_n,
    input  logic [2:0]             inst_w,
    output logic [psum_bw*col-1:0] out_s,
    output logic [col-1:0]         valid
);
    localparam int lat = row + col - 1;

    function automatic logic [psum_bw-1:0] mac_term(input logic [bw-1:0] a, input logic [bw-1:0] w);
        logic [2*bw-1:0] prod;
        prod = {{bw{a[bw-1]}}, a} * {{bw{w[bw-1]}}, w};
        return {{(psum_bw-2*bw){prod[2*bw-1]}}, prod};
    endfunction

`ifdef MAC_ARRAY_SKEWED_L1_EN
    function automatic logic [psum_bw-1:0] l1_term(input logic [bw-1:0] a, input logic [bw-1:0] w);
        logic [bw:0] diff;
        logic [bw:0] mag;
        diff = {a[bw-1], a} - {w[bw-1], w};
        mag  = diff[bw] ? (~diff + {{bw{1'b0}}, 1'b1}) : diff;
        return {{(psum_bw-bw-1){1'b0}}, mag};
    endfunction
`endif

    logic load_s;
    logic exec_s;
    assign load_s = inst_w[0];
    assign exec_s = inst_w[1] & ~inst_w[0];

    logic [bw-1:0]      w_r      [row][col];
    logic [bw-1:0]      a_r      [row][col];
    logic [psum_bw-1:0] p_r      [row][col];
    logic [bw-1:0]      a_in_s   [row][col];
    logic [psum_bw-1:0] p_in_s   [row][col];
    logic [psum_bw-1:0] p_nxt_s  [row][col];
    logic [bw-1:0]      act_sk_s [row];
    logic [psum_bw-1:0] top_sk_s [col];
    logic [psum_bw*col-1:0] bot_s;
    logic [lat-1:0]         tok_r;
    logic                   valid_r;
    logic [psum_bw*col-1:0] out_r;

`ifdef MAC_ARRAY_SKEWED_L1_EN
    logic m_r    [row][col];
    logic m_in_s [row][col];
    logic m_sk_s [row];
`else
    logic unused_mode_s;
    assign unused_mode_s = inst_w[2];
`endif

    // Row r activations (and mode) are delayed r cycles so the wavefront meets the psums
    for (genvar r = 0; r < row; r++) begin : g_rsk
        if (r == 0) begin : g_d0
            assign act_sk_s[r] = in_w[r*bw +: bw];
`ifdef MAC_ARRAY_SKEWED_L1_EN
            assign m_sk_s[r] = inst_w[2];
`endif
        end else begin : g_dn
            mas_delay #(.W(bw), .D(r)) u_act (
                .clk(clk), .reset(reset), .din(in_w[r*bw +: bw]), .dout(act_sk_s[r]));
`ifdef MAC_ARRAY_SKEWED_L1_EN
            mas_delay #(.W(1), .D(r)) u_mode (
                .clk(clk), .reset(reset), .din(inst_w[2]), .dout(m_sk_s[r]));
`endif
        end
    end

    for (genvar c = 0; c < col; c++) begin : g_csk
        if (c == 0) begin : g_d0
            assign top_sk_s[c] = in_n[c*psum_bw +: psum_bw];
        end else begin : g_dn
            mas_delay #(.W(psum_bw), .D(c)) u_top (
                .clk(clk), .reset(reset), .din(in_n[c*psum_bw +: psum_bw]), .dout(top_sk_s[c]));
        end
    end

    for (genvar r = 0; r < row; r++) begin : g_pr
        for (genvar c = 0; c < col; c++) begin : g_pc
            if (c == 0) begin : g_aw
                assign a_in_s[r][c] = act_sk_s[r];
`ifdef MAC_ARRAY_SKEWED_L1_EN
                assign m_in_s[r][c] = m_sk_s[r];
`endif
            end else begin : g_ai
                assign a_in_s[r][c] = a_r[r][c-1];
`ifdef MAC_ARRAY_SKEWED_L1_EN
                assign m_in_s[r][c] = m_r[r][c-1];
`endif
            end
            if (r == 0) begin : g_pt
                assign p_in_s[r][c] = top_sk_s[c];
            end else begin : g_pi
                assign p_in_s[r][c] = p_r[r-1][c];
            end
`ifdef MAC_ARRAY_SKEWED_L1_EN
            assign p_nxt_s[r][c] = p_in_s[r][c] + (m_in_s[r][c] ? l1_term(a_in_s[r][c], w_r[r][c])
                                                               : mac_term(a_in_s[r][c], w_r[r][c]));
`else
            assign p_nxt_s[r][c] = p_in_s[r][c] + mac_term(a_in_s[r][c], w_r[r][c]);
`endif
        end
    end

    // Column c bottom is delayed col-1-c cycles so all lanes line up
    for (genvar c = 0; c < col; c++) begin : g_dsk
        if (c == col - 1) begin : g_d0
            assign bot_s[c*psum_bw +: psum_bw] = p_r[row-1][c];
        end else begin : g_dn
            mas_delay #(.W(psum_bw), .D(col-1-c)) u_dsk (
                .clk(clk), .reset(reset), .din(p_r[row-1][c]), .dout(bot_s[c*psum_bw +: psum_bw]));
        end
    end

    // Weight chains and PE pipeline registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < row; r++) begin
                for (int c = 0; c < col; c++) begin
                    w_r[r][c] <= '0;
                    a_r[r][c] <= '0;
                    p_r[r][c] <= '0;
`ifdef MAC_ARRAY_SKEWED_L1_EN
                    m_r[r][c] <= 1'b0;
`endif
                end
            end
        end else begin
            for (int r = 0; r < row; r++) begin
                if (load_s) begin
                    w_r[r][0] <= in_w[r*bw +: bw];
                    for (int c = 1; c < col; c++) w_r[r][c] <= w_r[r][c-1];
                end
                for (int c = 0; c < col; c++) begin
                    a_r[r][c] <= a_in_s[r][c];
                    p_r[r][c] <= p_nxt_s[r][c];
`ifdef MAC_ARRAY_SKEWED_L1_EN
                    m_r[r][c] <= m_in_s[r][c];
`endif
                end
            end
        end
    end

    // Valid tokens travel alongside the vector; out_s only updates when one arrives
    always_ff @(posedge clk) begin
        if (reset) begin
            tok_r   <= '0;
            valid_r <= 1'b0;
            out_r   <= '0;
        end else begin
            tok_r[0] <= exec_s;
            for (int i = 1; i < lat; i++) tok_r[i] <= tok_r[i-1];
            valid_r <= tok_r[lat-1];
            if (tok_r[lat-1]) out_r <= bot_s;
        end
    end

    assign out_s = out_r;
    assign valid = {col{valid_r}};
endmodule

// File: tb/tb_mac_array_skewed.sv
// Scoreboard bench for mac_array_skewed: directed plan vectors plus randomized load/execute traffic.
module tb_mac_array_skewed;
    localparam int BW = 4, PBW = 16, ROW = 8, COL = 4, L = ROW + COL - 1;

    logic clk = 1'b0;
    logic reset;
    logic [ROW*BW-1:0]  in_w;
    logic [PBW*COL-1:0] in_n;
    logic [2:0]         inst_w;
    logic [PBW*COL-1:0] out_s;
    logic [COL-1:0]     valid;

    mac_array_skewed #(.bw(BW), .psum_bw(PBW), .row(ROW), .col(COL)) dut (
        .clk(clk), .reset(reset), .in_w(in_w), .in_n(in_n),
        .inst_w(inst_w), .out_s(out_s), .valid(valid));

    always #5 clk = ~clk;

    typedef struct {
        int                 due;
        logic [PBW*COL-1:0] data;
    } exp_t;

    exp_t               sbq[$];
    exp_t               mon_e;
    int                 cyc = 0;
    logic               rst_q = 1'b0;
    bit                 mon_on = 1'b0;
    int                 total = 0;
    int                 bad = 0;
    logic [PBW*COL-1:0] last_out = '0;
    logic [BW-1:0]      wm [ROW][COL];

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    function automatic int sx(input logic [BW-1:0] v);
        return v[BW-1] ? int'(v) - (1 << BW) : int'(v);
    endfunction

    // Reference: each column sum is in_n plus the sum over rows of a*w or |a-w|, modulo 2^16
    function automatic logic [PBW*COL-1:0] model(input logic [ROW*BW-1:0] aw,
                                                 input logic [PBW*COL-1:0] nn, input bit l1);
        logic [PBW*COL-1:0] res;
        for (int c = 0; c < COL; c++) begin
            int s;
            s = int'(nn[c*PBW +: PBW]);
            for (int r = 0; r < ROW; r++) begin
                int a, w;
                a = sx(aw[r*BW +: BW]);
                w = sx(wm[r][c]);
                if (l1) s += (a > w) ? a - w : w - a;
                else    s += a * w;
            end
            res[c*PBW +: PBW] = PBW'(s);
        end
        return res;
    endfunction

    task automatic drive(input bit rst, input logic [2:0] inst, input logic [ROW*BW-1:0] aw,
                         input logic [PBW*COL-1:0] nn, input bit use_exp,
                         input logic [PBW*COL-1:0] exp_v);
        exp_t e;
        bit   l1;
`ifdef MAC_ARRAY_SKEWED_L1_EN
        l1 = inst[2];
`else
        l1 = 1'b0;
`endif
        @(posedge clk);
        #1;
        reset = rst; inst_w = inst; in_w = aw; in_n = nn;
        if (rst) begin
            while (sbq.size() > 0 && sbq[$].due > cyc) void'(sbq.pop_back());
            for (int r = 0; r < ROW; r++)
                for (int c = 0; c < COL; c++) wm[r][c] = '0;
        end else if (inst[0]) begin
            for (int r = 0; r < ROW; r++) begin
                for (int c = COL - 1; c > 0; c--) wm[r][c] = wm[r][c-1];
                wm[r][0] = aw[r*BW +: BW];
            end
        end else if (inst[1]) begin
            e.due  = cyc + 1 + L;
            e.data = use_exp ? exp_v : model(aw, nn, l1);
            sbq.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 3'b000, $urandom(), {$urandom(), $urandom()}, 1'b0, '0);
    endtask

    task automatic load_all(input logic [BW-1:0] v, input int n);
        repeat (n) drive(1'b0, 3'b001, {ROW{v}}, '0, 1'b0, '0);
    endtask

    task automatic exec_c(input logic [2:0] inst, input logic [BW-1:0] a,
                          input logic [PBW-1:0] n, input logic [PBW*COL-1:0] ev);
        drive(1'b0, inst, {ROW{a}}, {COL{n}}, 1'b1, ev);
    endtask

    // Monitor: every cycle is either a scheduled result or must show valid low with out_s held
    always @(negedge clk) begin
        if (rst_q) begin
            mon_on = 1'b1;
            total++;
            if (valid !== '0 || out_s !== '0) begin
                bad++;
                $display("FAIL reset_clear: valid=%h out_s=%h, expected both 0", valid, out_s);
            end
            last_out = '0;
        end else if (mon_on) begin
            total++;
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                mon_e = sbq.pop_front();
                if (valid !== {COL{1'b1}} || out_s !== mon_e.data) begin
                    bad++;
                    $display("FAIL result @%0d: valid=%b out_s=%h, expected valid=1111 out_s=%h",
                             cyc, valid, out_s, mon_e.data);
                end
                last_out = mon_e.data;
            end else if (valid !== '0 || out_s !== last_out) begin
                bad++;
                $display("FAIL idle_hold @%0d: valid=%b out_s=%h, expected valid=0 out_s=%h",
                         cyc, valid, out_s, last_out);
            end
        end
    end

    initial begin
        reset = 1'b1; inst_w = 3'b000; in_w = '0; in_n = '0;
        repeat (2) drive(1'b1, 3'b000, '0, '0, 1'b0, '0);

        // Basic MAC then streaming, bubble and wrap-around with unit weights
        load_all(4'h1, COL);
        exec_c(3'b010, 4'h2, 16'h0000, {COL{16'd16}});
        exec_c(3'b010, 4'h1, 16'h0000, {COL{16'd8}});
        exec_c(3'b010, 4'h2, 16'h0000, {COL{16'd16}});
        exec_c(3'b010, 4'h3, 16'h0000, {COL{16'd24}});
        idle(1);
        exec_c(3'b010, 4'h1, 16'h0000, {COL{16'd8}});
        idle(1);
        exec_c(3'b010, 4'h2, 16'h0000, {COL{16'd16}});
        exec_c(3'b010, 4'h1, 16'hFFFF, {COL{16'h0007}});
        idle(L + 1);

        // Negative weights: L1 versus MAC
        load_all(4'hF, COL);
`ifdef MAC_ARRAY_SKEWED_L1_EN
        exec_c(3'b110, 4'h7, 16'h0000, {COL{16'd64}});
`else
        exec_c(3'b110, 4'h7, 16'h0000, {COL{16'hFFC8}});
`endif
        exec_c(3'b010, 4'h7, 16'h0000, {COL{16'hFFC8}});
        idle(L + 1);

        // Column ordering: load cycle k carries k+1, column c keeps cycle col-1-c
        for (int k = 0; k < COL; k++) load_all(BW'(k + 1), 1);
        exec_c(3'b010, 4'h1, 16'h0000, {16'd8, 16'd16, 16'd24, 16'd32});
        idle(L + 1);

        // x11 loads only: no valid appears, weights become 2
        drive(1'b0, 3'b011, {ROW{4'h2}}, '0, 1'b0, '0);
        drive(1'b0, 3'b111, {ROW{4'h2}}, '0, 1'b0, '0);
        drive(1'b0, 3'b011, {ROW{4'h2}}, '0, 1'b0, '0);
        drive(1'b0, 3'b011, {ROW{4'h2}}, '0, 1'b0, '0);
        exec_c(3'b010, 4'h1, 16'h0000, {COL{16'd16}});
        idle(L + 1);

        // Reset 5 cycles after an execute; first post-reset execute sees zero weights
        exec_c(3'b010, 4'h3, 16'h0000, {COL{16'd48}});
        idle(4);
        drive(1'b1, 3'b000, '0, '0, 1'b0, '0);
        drive(1'b1, 3'b010, '0, '0, 1'b0, '0);
        exec_c(3'b010, 4'h5, 16'h1234, {COL{16'h1234}});
        idle(L + 1);

        // Randomized traffic: drain, reload random weights, then a random execute/bubble burst
        for (int blk = 0; blk < 12; blk++) begin
            for (int k = 0; k < COL; k++)
                drive(1'b0, {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1},
                      $urandom(), {$urandom(), $urandom()}, 1'b0, '0);
            repeat ($urandom_range(10, 30)) begin
                if ($urandom_range(0, 3) != 0)
                    drive(1'b0, {1'($urandom_range(0, 1)), 2'b10}, $urandom(),
                          {$urandom(), $urandom()}, 1'b0, '0);
                else
                    idle(1);
            end
            idle(L + 1);
        end

        idle(2);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL pending: %0d results never appeared, expected 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mac_array_skewed.md
# mac_array_skewed

Parametrised weight-stationary systolic MAC array of `row` × `col` processing elements (PEs) for the k-furthest-neighbours datapath. It is the successor to the single-column MAC array. New behaviour:
- arbitrary column count;
- internal input skew and output deskew, so callers present aligned vectors and receive aligned results;
- a per-vector L1-distance mode.

It sits between the activation/weight SRAM readout and the partial-sum accumulator/sorter.

## Interface
- `bw`, 4: activation/weight width, signed two's complement.
- `psum_bw`, 16: partial-sum width; must be ≥ 2·`bw`+1.
- `row`, 8: PE rows, i.e. reduction depth; ≥ 1.
- `col`, 4: PE columns, i.e. output channels; ≥ 1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_w`  in  `row`·`bw`  lane r = activation (execute) or weight (load) for row r.
- `in_n`  in  `psum_bw`·`col`  lane c = initial partial sum injected at top of column c.
- `inst_w`  in  3  [0] kernel load, [1] execute, [2] mode (0 = MAC, 1 = L1).
- `out_s`  out  `psum_bw`·`col`  lane c = finished sum of column c.
- `valid`  out  `col`  per-column result-valid; all bits rise together.

## Operation
- **Load** (`inst_w[0]`=1): each row's weight register chain shifts east by one column, and `in_w` lane r enters column 0.
  - After `col` consecutive load cycles, column c holds the weight from load cycle `col`-1-c.
  - Non-load cycles hold weights.
  - Load has priority. `inst_w`=x11 performs the load only; no execute is launched.
- **Execute** (`inst_w[1:0]`=10): launches one vector. Input skew registers delay row r by r cycles and `in_n` lane c by c cycles. Mode bit `inst_w[2]` travels with the vector.
  - Activations move east one PE per cycle.
  - Partial sums move south one PE per cycle through a registered PE output.
- **PE(r,c) arithmetic:**
  - MAC mode: psum_out = psum_in + sext(a·w), where a·w is a signed 2·`bw` product.
  - L1 mode: psum_out = psum_in + zext(|a−w|), with |a−w| computed at `bw`+1 bits.
  - All sums wrap modulo 2^`psum_bw`. No saturation.
- **Output:** the deskew delays column c by `col`-1-c cycles, so every lane of `out_s` carries the same vector in the same cycle.
- **Weight changes with vectors in flight:** each PE uses the weight it holds when the vector reaches it. The driver must drain for L cycles before reloading.
- **Reset** clears:
  - weights, skew, deskew and pipeline registers to 0;
  - all in-flight valid tokens, so no pre-reset vector ever emerges;
  - `out_s` = 0 and `valid` = 0.

## Timing
- Latency L = `row`+`col`−1 cycles. An execute sampled at edge t produces `out_s`/`valid` registered at edge t+L.
  - Defaults: L = 11.
  - `row`=8, `col`=1: L = 8.
- Throughput: one vector per cycle. Back-to-back executes give consecutive `valid` cycles.
- `valid` is high for exactly one cycle per launched vector.
- `out_s` holds its last value when `valid`=0.
- Load takes effect on the weight registers at the sampling edge. The first execute may be issued in the cycle after the last load.
- `reset` sampled high at edge t: outputs are 0 from edge t onward. Inputs sampled in the first cycle after deassertion are honoured.
- An idle cycle (`inst_w[1:0]`=00) injects a bubble: `valid`=0 L cycles later.

## Configuration
- Macro: `MAC_ARRAY_SKEWED_L1_EN`.
- Defined: `inst_w[2]` selects L1 mode as described above, and the mode bit is pipelined per vector.
- Undefined:
  - `inst_w[2]` is ignored and every PE is MAC-only;
  - no mode pipeline or abs-diff logic is built;
  - an execute with `inst_w[2]`=1 computes MAC.

## Test plan
All scenarios use the defaults (`bw`=4, `psum_bw`=16, `row`=8, `col`=4) unless stated otherwise.
- **Basic MAC:** 4 load cycles with all lanes 4'h1, then execute with all activations 4'h2 and `in_n`=0 → at execute+11, `valid`=4'b1111 and every `out_s` lane = 16.
- **Signed, `col`=1:** load 4'hF (−1), execute with activation 4'h1 and `in_n`=2 → at execute+8, `out_s`=16'hFFFA (−6).
- **L1 (macro defined):** weights 4'hF, execute activation 4'h7 with `inst_w`=110 and `in_n`=0 → every lane = 64. With the macro undefined → every lane = 16'hFFC8 (−56).
- **Wrap-around:** weights 4'h1, activations 4'h1, `in_n`=16'hFFFF → lane = 16'h0007.
- **Streaming and ordering:**
  - Three back-to-back executes with activations 1, 2, 3 (weights 1) → `valid` high for 3 consecutive cycles with sums 8, 16, 24.
  - A bubble between executes gives a `valid` gap in the same position.
  - Column-c weight ordering is checked by loading distinct weights 1, 2, 3, 4 → column 0 = 4 × 8·a.
- **Reset mid-flight and load/execute conflict:**
  - Assert `reset` 5 cycles after an execute → `valid` and `out_s` are 0 and no result appears at execute+11.
  - `inst_w`=011 updates the weights and produces no `valid`.
